ntt_out_reorder: RTL and testbench
==================================

Name: ntt_out_reorder

Overview:
- Sits directly downstream of the dual-lane pipelined NTT and consumes its two-lane output stream.
- Each frame of N coefficients arrives in bit-reversed pair order. The block converts it to natural pair order, so out[0]=X[2j] and out[1]=X[2j+1].
- Uses a ping-pong buffer with two conflict-free banks, so one frame can be written while the previous frame is drained.

Parameters:
- N, default `DATA_SIZE (256): coefficients per frame. Power of two, at least 8. LOGN = log2(N).
- W, default `DATA_WIDTH: coefficient width in bits, signed.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_en  in  1  input pair valid, driven by the NTT out_en.
- in  in  2 x W signed  input pair, driven by the NTT out.
- out_en  out  1  output pair valid.
- out  out  2 x W signed  output pair in natural order.
- out_last  out  1  high with the final pair of each output frame.

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (rst).
- Reset state:
  - out_en=0, out_last=0, out=0.
  - Write counter, read counter and write-frame select are 0.
  - Both frame states are EMPTY.
  - Reset mid-frame discards any partial frame and any draining frame. Output is silent from the cycle after rst is sampled.
- Input order. The k-th in_en pulse of a frame (k = 0..N/2-1) carries:
  - lane0 = X[br(2k)], lane1 = X[br(2k)+N/2], where br is the LOGN-bit bit reversal.
  - in_en may be gapped arbitrarily. There is no backpressure.
- Storage: two frames (A and B). Each frame has two banks, each N/2 x W.
  - A coefficient with index i goes to bank i[0]^i[LOGN-1], at address i[LOGN-1:1].
  - Each write pair and each read pair maps one coefficient to each bank, so there is never a bank conflict.
- Write path:
  - Each in_en writes both lanes into the frame selected by wsel.
  - The write counter wcnt (LOGN-1 bits) increments once per in_en.
  - On the pulse where wcnt=N/2-1: wcnt wraps to 0, the frame state becomes FULL, and wsel toggles.
- Frame state machine, one per frame: EMPTY -> FILLING (first write) -> FULL (last write) -> DRAINING (read start) -> EMPTY (last read address issued).
- Read path:
  - Reading starts the cycle after a frame becomes FULL, provided no frame is DRAINING. Otherwise it starts the cycle the current drain ends.
  - Reading issues one address pair per cycle, rcnt = 0..N/2-1, with no gaps.
  - Pair j reads X[2j] and X[2j+1]; bank selection follows the mapping above.
  - Reads are registered. out, out_en and out_last are valid one cycle after the address is issued.
- Latency: if the last in_en of a frame is in cycle L and the reader is idle, out_en is high in cycles L+2 .. L+N/2+1. out_last is high in cycle L+N/2+1.
- Back-to-back frames:
  - The next frame's writes may start in cycle L+1 into the other frame.
  - Ungapped frames give a continuous out_en with no bubble between frames.
- Overflow:
  - It cannot occur by construction: a frame takes at least N/2 writes, and the drain takes exactly N/2 cycles.
  - An assertion checks that writes never target a frame that is FULL or DRAINING.
- Simultaneous events: a frame's final write and the other frame's final read address in the same cycle are legal. The drain of the newly full frame then begins the next cycle.
- Arithmetic: none. Data passes bit-exact and signed values are preserved.

Test Plan:
- N=8, rst, then pairs (X0,X4),(X2,X6),(X1,X5),(X3,X7) on 4 consecutive cycles with Xi=100+i. Required: out_en is high in cycles L+2..L+5 with (100,101),(102,103),(104,105),(106,107), and out_last is high with (106,107).
- N=8, the same frame with in_en gapped (pulses every 3rd cycle). Required: identical output values; out_en starts exactly 2 cycles after the 4th pulse and stays high for 4 contiguous cycles.
- N=8, two frames back-to-back with no gaps (second frame Xi=200+i). Required: 8 contiguous out_en cycles and out_last twice. After reset, out_en rises exactly once, 2 cycles after the first frame's last in_en.
- N=8, rst asserted after 2 pairs of a frame, then a full new frame with Xi=-5+i. Required: no output from the partial frame; output is (-5,-4),(-3,-2),(-1,0),(1,2), which checks sign preservation.
- N=256, 16 random frames with random gaps, checked against a bit-reversal reference model. Required: all pairs match, no bank-conflict or overflow assertion fires, and out_last count = 16.
- Reset check: hold rst for 3 cycles with random in/in_en. Required: out_en=0, out_last=0 and out=0 throughout, and for 1 cycle after release.

Source files
------------

// File: rtl/ntt_out_reorder.sv
// ntt_out_reorder: converts the bit-reversed two-lane NTT output stream into
// natural pair order using a ping-pong pair of frames, each split into two
// banks so every write pair and every read pair touches both banks once.

`ifndef DATA_SIZE
`define DATA_SIZE 256
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module ntt_out_reorder #(
    parameter int unsigned N = `DATA_SIZE,
    parameter int unsigned W = `DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_en,
    input  logic signed [W-1:0] in [2],
    output logic                out_en,
    output logic signed [W-1:0] out [2],
    output logic                out_last
);
    localparam int unsigned LOGN = $clog2(N);
    localparam int unsigned HALF = N / 2;
    localparam int unsigned CW   = LOGN - 1;

    localparam logic [1:0] ST_EMPTY    = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_FULL     = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    // Coefficient i lives in bank (i[0] ^ i[LOGN-1]) at address i[LOGN-1:1].
    logic signed [W-1:0] bank0 [2][HALF];
    logic signed [W-1:0] bank1 [2][HALF];

    logic [CW-1:0]   wcnt, wcnt_nxt;
    logic [CW-1:0]   rcnt, rcnt_nxt;
    logic            wsel, wsel_nxt;
    logic            rsel, rsel_nxt;
    logic            rbusy, rbusy_nxt;
    logic [1:0]      fstate     [2];
    logic [1:0]      fstate_nxt [2];

    logic [LOGN-1:0] widx_c;
    logic            wbank_c;
    logic [CW-1:0]   waddr0_c;
    logic [CW-1:0]   waddr1_c;
    logic            rbank_c;
    logic            wr_last_c;
    logic            rd_start_c;
    logic            rd_issue_c;
    logic            rd_last_c;

    function automatic logic [LOGN-1:0] bit_rev(input logic [LOGN-1:0] x);
        logic [LOGN-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LOGN); i++) begin
            r[i] = x[int'(LOGN) - 1 - i];
        end
        return r;
    endfunction

    // Write-side address/bank decode: lane0 holds X[br(2k)], lane1 holds X[br(2k)+N/2].
    always_comb begin
        widx_c   = bit_rev({wcnt, 1'b0});
        wbank_c  = widx_c[0] ^ widx_c[LOGN-1];
        waddr0_c = widx_c[LOGN-1:1];
        waddr1_c = {1'b1, widx_c[LOGN-2:1]};
        rbank_c  = rcnt[CW-1];
    end

    // Next-state logic for the write counter, reader and both frame FSMs.
    always_comb begin
        wcnt_nxt   = wcnt;
        wsel_nxt   = wsel;
        rcnt_nxt   = rcnt;
        rsel_nxt   = rsel;
        rbusy_nxt  = rbusy;
        fstate_nxt = fstate;

        wr_last_c  = in_en && (wcnt == CW'(HALF - 1));
        rd_start_c = !rbusy && (fstate[rsel] == ST_FULL);
        rd_issue_c = rbusy || rd_start_c;
        rd_last_c  = rd_issue_c && (rcnt == CW'(HALF - 1));

        if (in_en) begin
            wcnt_nxt = wcnt + CW'(1);
            if (wr_last_c) begin
                fstate_nxt[wsel] = ST_FULL;
                wsel_nxt         = ~wsel;
            end else if (fstate[wsel] == ST_EMPTY) begin
                fstate_nxt[wsel] = ST_FILLING;
            end
        end

        if (rd_issue_c) begin
            rcnt_nxt  = rcnt + CW'(1);
            rbusy_nxt = 1'b1;
            if (rd_start_c) begin
                fstate_nxt[rsel] = ST_DRAINING;
            end
            if (rd_last_c) begin
                fstate_nxt[rsel] = ST_EMPTY;
                rbusy_nxt        = 1'b0;
                rsel_nxt         = ~rsel;
            end
        end
    end

    // Control state registers; reset drops any partial or draining frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt      <= '0;
            rcnt      <= '0;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            rbusy     <= 1'b0;
            fstate[0] <= ST_EMPTY;
            fstate[1] <= ST_EMPTY;
        end else begin
            wcnt      <= wcnt_nxt;
            rcnt      <= rcnt_nxt;
            wsel      <= wsel_nxt;
            rsel      <= rsel_nxt;
            rbusy     <= rbusy_nxt;
            fstate[0] <= fstate_nxt[0];
            fstate[1] <= fstate_nxt[1];
        end
    end

    // Buffer writes: the two lanes always land in opposite banks.
    always_ff @(posedge clk) begin
        if (in_en) begin
            if (wbank_c) begin
                bank1[wsel][waddr0_c] <= in[0];
                bank0[wsel][waddr1_c] <= in[1];
            end else begin
                bank0[wsel][waddr0_c] <= in[0];
                bank1[wsel][waddr1_c] <= in[1];
            end
        end
    end

    // Registered read: pair j = (X[2j], X[2j+1]), both at address j in opposite banks.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_en   <= 1'b0;
            out_last <= 1'b0;
            out[0]   <= '0;
            out[1]   <= '0;
        end else begin
            out_en   <= rd_issue_c;
            out_last <= rd_last_c;
            if (rd_issue_c) begin
                out[0] <= rbank_c ? bank1[rsel][rcnt] : bank0[rsel][rcnt];
                out[1] <= rbank_c ? bank0[rsel][rcnt] : bank1[rsel][rcnt];
            end else begin
                out[0] <= '0;
                out[1] <= '0;
            end
        end
    end

    // Writes must only ever target a frame that is free or already filling.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        in_en |-> (fstate[wsel] == ST_EMPTY || fstate[wsel] == ST_FILLING));

endmodule

// File: tb/tb_ntt_out_reorder.sv
// Bench for ntt_out_reorder: an N=8 instance for directed frames and an N=256
// instance for random frames, with a scoreboard fed by a reference model.

module tb_ntt_out_reorder;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                rst0, rst1, en0, en1;
    logic signed [W-1:0] in0 [2];
    logic signed [W-1:0] in1 [2];
    logic signed [W-1:0] out0 [2];
    logic signed [W-1:0] out1 [2];
    logic                oen0, oen1, olast0, olast1;

    ntt_out_reorder #(.N(8), .W(W)) u8 (
        .clk(clk), .rst(rst0), .in_en(en0), .in(in0),
        .out_en(oen0), .out(out0), .out_last(olast0)
    );

    ntt_out_reorder #(.N(256), .W(W)) u256 (
        .clk(clk), .rst(rst1), .in_en(en1), .in(in1),
        .out_en(oen1), .out(out1), .out_last(olast1)
    );

    typedef struct {
        int cyc;
        int d0;
        int d1;
        bit last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   last_end [2];
    int   nlast [2];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic int br(input int x, input int logn);
        int r = 0;
        for (int i = 0; i < logn; i++) begin
            if (x[i]) r |= (1 << (logn - 1 - i));
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int inst, input bit en, input int a, input int b);
        @(posedge clk);
        #1;
        if (inst == 0) begin
            en0 = en; in0[0] = W'(a); in0[1] = W'(b);
        end else begin
            en1 = en; in1[0] = W'(a); in1[1] = W'(b);
        end
    endtask

    task automatic idle(input int inst, input int n);
        repeat (n) step(inst, 1'b0, 0, 0);
    endtask

    // Reference: frame complete at L emerges at max(L+2, previous drain end+1), natural pair order.
    task automatic push_frame(input int inst, input int n, input int xs[$], input int l);
        int   start;
        exp_t e;
        start = (l + 2 > last_end[inst] + 1) ? l + 2 : last_end[inst] + 1;
        for (int j = 0; j < n / 2; j++) begin
            e.cyc  = start + j;
            e.d0   = xs[2*j];
            e.d1   = xs[2*j+1];
            e.last = (j == n / 2 - 1);
            if (inst == 0) q0.push_back(e);
            else           q1.push_back(e);
        end
        last_end[inst] = start + n / 2 - 1;
    endtask

    task automatic send_frame(input int inst, input int xs[$], input int gap, input bit rnd_gap);
        int n    = (inst == 0) ? 8 : 256;
        int logn = (inst == 0) ? 3 : 8;
        int g;
        for (int k = 0; k < n / 2; k++) begin
            if (rnd_gap) g = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
            else         g = (k == 0) ? 0 : gap;
            idle(inst, g);
            step(inst, 1'b1, xs[br(2*k, logn)], xs[br(2*k, logn) + n/2]);
        end
        push_frame(inst, n, xs, cyc);
    endtask

    task automatic flush(input int inst);
        if (inst == 0) q0.delete();
        else           q1.delete();
        last_end[inst] = -100;
    endtask

    task automatic set_in(input int inst, input bit r, input bit rnd);
        logic signed [W-1:0] a, b;
        a = W'($urandom);
        b = W'($urandom);
        if (inst == 0) begin
            rst0 = r; en0 = rnd ? 1'($urandom) : 1'b0; in0[0] = a; in0[1] = b;
        end else begin
            rst1 = r; en1 = rnd ? 1'($urandom) : 1'b0; in1[0] = a; in1[1] = b;
        end
    endtask

    // Hold rst for 'hold' cycles, then check silence through one cycle after release.
    task automatic do_reset(input int inst, input int hold, input bit rnd);
        bit oe, ol;
        int a, b;
        @(posedge clk);
        #1;
        set_in(inst, 1'b1, rnd);
        for (int i = 1; i < hold + 2; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) flush(inst);
            if (i < hold) set_in(inst, 1'b1, rnd);
            else          set_in(inst, 1'b0, 1'b0);
            @(negedge clk);
            oe = (inst == 0) ? oen0 : oen1;
            ol = (inst == 0) ? olast0 : olast1;
            a  = (inst == 0) ? int'(out0[0]) : int'(out1[0]);
            b  = (inst == 0) ? int'(out0[1]) : int'(out1[1]);
            chk("reset out_en", int'(oe), 0);
            chk("reset out_last", int'(ol), 0);
            chk("reset out0", a, 0);
            chk("reset out1", b, 0);
        end
    endtask

    task automatic mon(input int inst, input logic en, input logic last, input int a, input int b);
        exp_t e;
        if (last === 1'b1 && en !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL stray_last inst%0d: out_last=1 with out_en=0 (cycle %0d)", inst, cyc);
        end
        if (en === 1'b1) begin
            if ((inst == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out inst%0d: out_en=1 got (%0d,%0d) expected none (cycle %0d)",
                         inst, a, b, cyc);
            end else begin
                e = (inst == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("inst%0d cycle", inst), cyc, e.cyc);
                chk($sformatf("inst%0d out0", inst), a, e.d0);
                chk($sformatf("inst%0d out1", inst), b, e.d1);
                chk($sformatf("inst%0d out_last", inst), int'(last === 1'b1), int'(e.last));
                if (last === 1'b1) nlast[inst]++;
            end
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        mon(0, oen0, olast0, int'(out0[0]), int'(out0[1]));
        mon(1, oen1, olast1, int'(out1[0]), int'(out1[1]));
    end

    initial begin
        int xs[$];
        int ys[$];
        int nl;
        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        in0[0] = '0; in0[1] = '0; in1[0] = '0; in1[1] = '0;
        last_end[0] = -100; last_end[1] = -100;
        nlast[0] = 0; nlast[1] = 0;
        repeat (2) @(posedge clk);

        // Reset with random inputs on both instances
        do_reset(0, 3, 1'b1);
        do_reset(1, 3, 1'b1);

        // Single ungapped N=8 frame
        for (int i = 0; i < 8; i++) xs.push_back(100 + i);
        nl = nlast[0];
        send_frame(0, xs, 0, 1'b0);
        idle(0, 8);
        chk("frame1 last count", nlast[0] - nl, 1);

        // Same frame, one pulse every 3rd cycle
        send_frame(0, xs, 2, 1'b0);
        idle(0, 8);

        // Two back-to-back frames after reset
        do_reset(0, 1, 1'b0);
        for (int i = 0; i < 8; i++) ys.push_back(200 + i);
        nl = nlast[0];
        send_frame(0, xs, 0, 1'b0);
        send_frame(0, ys, 0, 1'b0);
        idle(0, 10);
        chk("b2b last count", nlast[0] - nl, 2);

        // Partial frame dropped by reset, then a signed frame
        do_reset(0, 1, 1'b0);
        step(0, 1'b1, 1000, 1001);
        step(0, 1'b1, 1002, 1003);
        do_reset(0, 1, 1'b0);
        xs.delete();
        for (int i = 0; i < 8; i++) xs.push_back(-5 + i);
        send_frame(0, xs, 0, 1'b0);
        idle(0, 8);

        // 16 random N=256 frames with random gaps
        do_reset(1, 1, 1'b0);
        nlast[1] = 0;
        for (int f = 0; f < 16; f++) begin
            xs.delete();
            for (int i = 0; i < 256; i++) begin
                logic signed [W-1:0] v;
                v = W'($urandom);
                xs.push_back(int'(v));
            end
            send_frame(1, xs, 0, 1'b1);
        end
        idle(1, 1);

        for (int i = 0; i < 2000 && (q0.size() != 0 || q1.size() != 0); i++) @(posedge clk);
        @(negedge clk);
        chk("q0 drained", q0.size(), 0);
        chk("q1 drained", q1.size(), 0);
        chk("random out_last count", nlast[1], 16);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
